// File: rtl/rd_addr_gen_if.sv
// Bus bundle for the frame-buffer read address generator: frame trigger,
// burst-address handshake, returning beat strobe and status flags.
interface rd_addr_gen_if;
    logic        frame_start;
    logic [31:0] addr;
    logic        addr_valid;
    logic        addr_ready;
    logic        data_valid;
    logic [2:0]  outstanding;
    logic        busy;
    logic        frame_done;
    logic        overrun;

    // Generator side: drives the addresses and status.
    modport master (
        input  frame_start,
        input  addr_ready,
        input  data_valid,
        output addr,
        output addr_valid,
        output outstanding,
        output busy,
        output frame_done,
        output overrun
    );

    // Timing logic / memory side: triggers frames, accepts addresses, returns beats.
    modport slave (
        output frame_start,
        output addr_ready,
        output data_valid,
        input  addr,
        input  addr_valid,
        input  outstanding,
        input  busy,
        input  frame_done,
        input  overrun
    );
endinterface

// File: rtl/rd_addr_gen.sv
// Read-side frame buffer address generator. Walks the frame region in burst
// steps, issues burst addresses over valid/ready, limits bursts in flight and
// retires them by counting returning data beats.
module rd_addr_gen #(
    parameter logic [31:0] BASE_ADDR       = 32'h0F80_0000,
    parameter logic [31:0] FRAME_BYTES     = 32'h1A00_0000,
    parameter int unsigned BURST_BYTES     = 128,
    parameter int unsigned BURST_BEATS     = 16,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    rd_addr_gen_if.master bus
);

    localparam int unsigned     BEAT_W    = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_BEATS - 1);
    localparam logic [32:0]     BURST_INC = 33'(BURST_BYTES);
    localparam logic [32:0]     FRAME_END = {1'b0, FRAME_BYTES};
    localparam logic [2:0]      MAX_OUT   = 3'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       offset_q, offset_d;
    logic [31:0]       addr_q, addr_d;
    logic              addr_valid_q, addr_valid_d;
    logic [2:0]        outstanding_q, outstanding_d;
    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic              frame_done_q, frame_done_d;
    logic              overrun_q, overrun_d;

    logic              handshake;
    logic              retire;
    logic [32:0]       offset_next;

    // State and datapath registers; reset abandons any frame in progress.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= IDLE;
            offset_q      <= '0;
            addr_q        <= BASE_ADDR;
            addr_valid_q  <= 1'b0;
            outstanding_q <= '0;
            beat_cnt_q    <= '0;
            frame_done_q  <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            offset_q      <= offset_d;
            addr_q        <= addr_d;
            addr_valid_q  <= addr_valid_d;
            outstanding_q <= outstanding_d;
            beat_cnt_q    <= beat_cnt_d;
            frame_done_q  <= frame_done_d;
            overrun_q     <= overrun_d;
        end
    end

    // Beat accounting, in-flight count and frame walk state machine.
    always_comb begin
        state_d      = state_q;
        offset_d     = offset_q;
        addr_d       = addr_q;
        addr_valid_d = addr_valid_q;
        beat_cnt_d   = beat_cnt_q;
        frame_done_d = 1'b0;
        overrun_d    = overrun_q;
        retire       = 1'b0;

        handshake   = addr_valid_q && bus.addr_ready;
        // 33-bit sum so a frame ending at the top of the space cannot wrap.
        offset_next = {1'b0, offset_q} + BURST_INC;

        // Beats with nothing in flight are strays and are dropped.
        if (bus.data_valid && (outstanding_q != 3'd0)) begin
            if (beat_cnt_q == LAST_BEAT) begin
                beat_cnt_d = '0;
                retire     = 1'b1;
            end else begin
                beat_cnt_d = beat_cnt_q + 1'b1;
            end
        end

        outstanding_d = outstanding_q;
        if (handshake && !retire) begin
            outstanding_d = outstanding_q + 3'd1;
        end else if (!handshake && retire) begin
            outstanding_d = outstanding_q - 3'd1;
        end

        case (state_q)
            IDLE: begin
                addr_valid_d = 1'b0;
                if (bus.frame_start) begin
                    state_d      = ISSUE;
                    offset_d     = '0;
                    addr_d       = BASE_ADDR;
                    addr_valid_d = (outstanding_d < MAX_OUT);
                    overrun_d    = 1'b0;
                end
            end
            ISSUE: begin
                if (bus.frame_start) begin
                    overrun_d = 1'b1;
                end
                if (handshake && (offset_next >= FRAME_END)) begin
                    state_d      = DRAIN;
                    addr_valid_d = 1'b0;
                end else begin
                    if (handshake) begin
                        offset_d = offset_next[31:0];
                        addr_d   = BASE_ADDR + offset_next[31:0];
                    end
                    // A held request never sees its count rise, so it stays up.
                    addr_valid_d = (outstanding_d < MAX_OUT);
                end
            end
            DRAIN: begin
                addr_valid_d = 1'b0;
                if (bus.frame_start) begin
                    overrun_d = 1'b1;
                end
                if (retire && (outstanding_q == 3'd1)) begin
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: begin
                state_d      = IDLE;
                addr_valid_d = 1'b0;
            end
        endcase
    end

    assign bus.addr        = addr_q;
    assign bus.addr_valid  = addr_valid_q;
    assign bus.outstanding = outstanding_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.frame_done  = frame_done_q;
    assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_rd_addr_gen.sv
// Bench for rd_addr_gen with a shortened 1 KiB frame (8 bursts). A directed
// vector table, hand sequences for the multi-cycle corners and a random run,
// all shadowed cycle by cycle by a transaction-count reference model.
module tb_rd_addr_gen;

    localparam logic [31:0] BASE   = 32'h0F80_0000;
    localparam logic [31:0] FRAME  = 32'd1024;
    localparam int          BURST  = 128;
    localparam int          BEATS  = 16;
    localparam int          MAXO   = 4;
    localparam int          TOTAL  = FRAME / BURST;

    logic sysClk  = 1'b0;
    logic sysRstN = 1'b1;

    int checks   = 0;
    int failures = 0;

    rd_addr_gen_if bus ();

    rd_addr_gen #(
        .BASE_ADDR      (BASE),
        .FRAME_BYTES    (FRAME),
        .BURST_BYTES    (BURST),
        .BURST_BEATS    (BEATS),
        .MAX_OUTSTANDING(MAXO)
    ) dut (
        .sys_clk  (sysClk),
        .sys_rst_n(sysRstN),
        .bus      (bus)
    );

    // Free-running 100 MHz clock.
    always #5 sysClk = ~sysClk;

    // Reference model: bursts issued and beats accepted since reset. In-flight
    // is issued minus completed bursts (beats / BEATS); an address is offered
    // whenever a frame is active, bursts remain and the cap is not reached.
    typedef struct packed {
        int   issued;
        int   beats;
        int   frameIssued;
        logic busy;
        logic done;
        logic overrun;
    } model_t;

    model_t m = '0;

    function automatic int inflightOf(model_t c);
        return c.issued - (c.beats / BEATS);
    endfunction

    function automatic logic validOf(model_t c);
        return c.busy && (c.frameIssued < TOTAL) && (inflightOf(c) < MAXO);
    endfunction

    function automatic model_t modelNext(model_t c, logic fs, logic rdy, logic dv);
        model_t n;
        logic   hs;
        n  = c;
        hs = validOf(c) && rdy;
        if (dv && (inflightOf(c) > 0)) n.beats = c.beats + 1;
        if (hs) begin
            n.issued      = c.issued + 1;
            n.frameIssued = c.frameIssued + 1;
        end
        n.done = c.busy && (n.frameIssued == TOTAL) && (inflightOf(n) == 0);
        if (c.busy) begin
            if (fs) n.overrun = 1'b1;
            if (n.done) n.busy = 1'b0;
        end else if (fs) begin
            n.busy        = 1'b1;
            n.frameIssued = 0;
            n.overrun     = 1'b0;
        end
        return n;
    endfunction

    // Advance the model on every clock edge; reset clears it like the DUT.
    always @(posedge sysClk or negedge sysRstN) begin
        if (!sysRstN) m <= '0;
        else          m <= modelNext(m, bus.frame_start, bus.addr_ready, bus.data_valid);
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic checkModel();
        checkOutput("mdl_valid", {31'd0, bus.addr_valid}, {31'd0, validOf(m)});
        checkOutput("mdl_outstanding", {29'd0, bus.outstanding}, 32'(inflightOf(m)));
        checkOutput("mdl_busy", {31'd0, bus.busy}, {31'd0, m.busy});
        checkOutput("mdl_frame_done", {31'd0, bus.frame_done}, {31'd0, m.done});
        checkOutput("mdl_overrun", {31'd0, bus.overrun}, {31'd0, m.overrun});
        if (validOf(m)) checkOutput("mdl_addr", bus.addr, BASE + 32'(m.frameIssued * BURST));
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_addr"}, bus.addr, BASE);
        checkOutput({tag, "_valid"}, {31'd0, bus.addr_valid}, 32'd0);
        checkOutput({tag, "_outstanding"}, {29'd0, bus.outstanding}, 32'd0);
        checkOutput({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
        checkOutput({tag, "_frame_done"}, {31'd0, bus.frame_done}, 32'd0);
        checkOutput({tag, "_overrun"}, {31'd0, bus.overrun}, 32'd0);
    endtask

    // Drive one cycle of inputs, let the edge pass, compare against the model.
    task automatic applyStimulus(input logic fs, input logic rdy, input logic dv);
        bus.frame_start = fs;
        bus.addr_ready  = rdy;
        bus.data_valid  = dv;
        @(posedge sysClk);
        #1;
        checkModel();
    endtask

    typedef struct {
        logic        fs;
        logic        rdy;
        logic        dv;
        logic        expValid;
        logic [31:0] expAddr;
        int          expOut;
        logic        expBusy;
        logic        expOverrun;
    } vec_t;

    vec_t vec[8];

    // Safety net in case a wait is never satisfied.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] seen[$];
        int          doneCount;
        int          guard;

        bus.frame_start = 1'b0;
        bus.addr_ready  = 1'b0;
        bus.data_valid  = 1'b0;

        vec[0] = '{1'b1, 1'b0, 1'b0, 1'b1, BASE,           0, 1'b1, 1'b0};
        vec[1] = '{1'b0, 1'b0, 1'b0, 1'b1, BASE,           0, 1'b1, 1'b0};
        vec[2] = '{1'b0, 1'b1, 1'b0, 1'b1, BASE + 32'h080, 1, 1'b1, 1'b0};
        vec[3] = '{1'b0, 1'b1, 1'b0, 1'b1, BASE + 32'h100, 2, 1'b1, 1'b0};
        vec[4] = '{1'b0, 1'b1, 1'b0, 1'b1, BASE + 32'h180, 3, 1'b1, 1'b0};
        vec[5] = '{1'b0, 1'b1, 1'b0, 1'b0, BASE + 32'h200, 4, 1'b1, 1'b0};
        vec[6] = '{1'b0, 1'b1, 1'b0, 1'b0, BASE + 32'h200, 4, 1'b1, 1'b0};
        vec[7] = '{1'b1, 1'b0, 1'b0, 1'b0, BASE + 32'h200, 4, 1'b1, 1'b1};

        $display("[TB] reset values");
        #1 sysRstN = 1'b0;
        #1 checkResetValues("rst");
        @(posedge sysClk);
        @(posedge sysClk);
        #3 sysRstN = 1'b1;

        $display("[TB] vector table: issue up to the cap, then overrun");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vec[i].fs, vec[i].rdy, vec[i].dv);
            checkOutput($sformatf("vec%0d_valid", i), {31'd0, bus.addr_valid}, {31'd0, vec[i].expValid});
            checkOutput($sformatf("vec%0d_addr", i), bus.addr, vec[i].expAddr);
            checkOutput($sformatf("vec%0d_out", i), {29'd0, bus.outstanding}, 32'(vec[i].expOut));
            checkOutput($sformatf("vec%0d_busy", i), {31'd0, bus.busy}, {31'd0, vec[i].expBusy});
            checkOutput($sformatf("vec%0d_overrun", i), {31'd0, bus.overrun}, {31'd0, vec[i].expOverrun});
        end

        $display("[TB] one burst returned releases the cap");
        for (int k = 0; k < BEATS; k++) applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("cap_release_out", {29'd0, bus.outstanding}, 32'd3);
        checkOutput("cap_release_valid", {31'd0, bus.addr_valid}, 32'd1);
        checkOutput("cap_release_addr", bus.addr, BASE + 32'h200);

        $display("[TB] handshake coinciding with final beat");
        for (int k = 0; k < BEATS - 1; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            checkOutput("hold_addr", bus.addr, BASE + 32'h200);
        end
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("coincide_out", {29'd0, bus.outstanding}, 32'd3);
        checkOutput("coincide_addr", bus.addr, BASE + 32'h280);

        $display("[TB] addr_ready low for 5 cycles");
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            checkOutput("stall_addr", bus.addr, BASE + 32'h280);
            checkOutput("stall_valid", {31'd0, bus.addr_valid}, 32'd1);
        end
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("stall_release_out", {29'd0, bus.outstanding}, 32'd4);
        checkOutput("stall_release_valid", {31'd0, bus.addr_valid}, 32'd0);

        $display("[TB] drain the overrun frame");
        doneCount = 0;
        guard     = 0;
        while (bus.busy && guard < 400) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
            if (bus.frame_done) doneCount++;
            guard++;
        end
        checkOutput("drain_timeout", {31'd0, bus.busy}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
            if (bus.frame_done) doneCount++;
        end
        checkOutput("drain_done_pulses", 32'(doneCount), 32'd1);
        checkOutput("drain_overrun_sticky", {31'd0, bus.overrun}, 32'd1);

        $display("[TB] restart clears overrun, full frame with ready held high");
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("restart_overrun", {31'd0, bus.overrun}, 32'd0);
        checkOutput("restart_addr", bus.addr, BASE);
        checkOutput("restart_valid", {31'd0, bus.addr_valid}, 32'd1);
        doneCount = 0;
        guard     = 0;
        while (bus.busy && guard < 400) begin
            if (bus.addr_valid) seen.push_back(bus.addr);
            applyStimulus(1'b0, 1'b1, 1'b1);
            if (bus.frame_done) doneCount++;
            guard++;
        end
        checkOutput("frame_timeout", {31'd0, bus.busy}, 32'd0);
        checkOutput("frame_burst_count", 32'(seen.size()), 32'(TOTAL));
        for (int i = 0; i < seen.size() && i < TOTAL; i++)
            checkOutput($sformatf("frame_addr%0d", i), seen[i], BASE + 32'(i * BURST));
        checkOutput("frame_done_pulses", 32'(doneCount), 32'd1);

        $display("[TB] asynchronous reset mid-frame");
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("pre_reset_out", {29'd0, bus.outstanding}, 32'd2);
        #3 sysRstN = 1'b0;
        #1 checkResetValues("async_rst");
        bus.addr_ready = 1'b0;
        bus.data_valid = 1'b1;
        @(posedge sysClk);
        #3 sysRstN = 1'b1;
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            checkOutput("stray_out", {29'd0, bus.outstanding}, 32'd0);
            checkOutput("stray_done", {31'd0, bus.frame_done}, 32'd0);
        end

        $display("[TB] randomized traffic against the model");
        for (int k = 0; k < 3000; k++) begin
            applyStimulus(($urandom_range(0, 59) == 0),
                          ($urandom_range(0, 9) < 7),
                          ($urandom_range(0, 9) < 6));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
